// File: rtl/isdu_pkg.sv
// Shared types and encodings for the LC-3 instruction sequence/decode unit.
// The ALU, PC mux and address mux encodings are also used by the datapath.
package isdu_pkg;

    typedef enum logic [4:0] {
        HALTED, FETCH1, FETCH2, FETCH3, DECODE,
        ADD, AND, NOT, BR, BR_TAKEN, JMP,
        JSR1, JSR2, LDR1, LDR_WAIT, LDR3,
        STR1, STR2, STR_WAIT, PAUSE1, PAUSE2
    } state_t;

    localparam logic [3:0] OP_BR    = 4'b0000;
    localparam logic [3:0] OP_ADD   = 4'b0001;
    localparam logic [3:0] OP_JSR   = 4'b0100;
    localparam logic [3:0] OP_AND   = 4'b0101;
    localparam logic [3:0] OP_LDR   = 4'b0110;
    localparam logic [3:0] OP_STR   = 4'b0111;
    localparam logic [3:0] OP_NOT   = 4'b1001;
    localparam logic [3:0] OP_JMP   = 4'b1100;
    localparam logic [3:0] OP_PAUSE = 4'b1101;

    localparam logic [1:0] ALUK_ADD   = 2'b00;
    localparam logic [1:0] ALUK_AND   = 2'b01;
    localparam logic [1:0] ALUK_NOT   = 2'b10;
    localparam logic [1:0] ALUK_PASSA = 2'b11;

    localparam logic [1:0] PCMUX_INC   = 2'b00;
    localparam logic [1:0] PCMUX_BUS   = 2'b01;
    localparam logic [1:0] PCMUX_ADDER = 2'b10;

    localparam logic [1:0] ADDR2_ZERO  = 2'b00;
    localparam logic [1:0] ADDR2_OFF6  = 2'b01;
    localparam logic [1:0] ADDR2_OFF9  = 2'b10;
    localparam logic [1:0] ADDR2_OFF11 = 2'b11;

    typedef struct packed {
        logic       ld_mar, ld_mdr, ld_ir, ld_ben, ld_cc, ld_reg, ld_pc, ld_led;
        logic       gate_pc, gate_mdr, gate_alu, gate_marmux;
        logic       sr1mux, drmux, sr2mux, addr1mux;
        logic [1:0] addr2mux, pcmux, aluk;
        logic       mio_en, mem_ce, mem_ub, mem_lb, mem_oe, mem_we;
    } ctrl_t;

    function automatic logic is_wait(input state_t s);
        return (s == FETCH2) || (s == LDR_WAIT) || (s == STR_WAIT);
    endfunction

endpackage

// File: rtl/isdu_mem_wait_ctr.sv
// Cycle counter for SRAM access states; done marks the final cycle of an access.
module mem_wait_ctr
    import isdu_pkg::*;
#(
    parameter int WAIT_CYCLES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic done
);

    logic [3:0] count;

    always_ff @(posedge clk) begin
        if (!rst_n)
            count <= '0;
        else if (clear)
            count <= '0;
        else if (enable)
            count <= count + 4'd1;
    end

    assign done = enable && (count == 4'(WAIT_CYCLES - 1));

endmodule

// File: rtl/isdu.sv
// LC-3 instruction sequence and decode unit: Moore FSM driving datapath,
// register file and SRAM controls.
module isdu
    import isdu_pkg::*;
#(
    parameter int MEM_WAIT_CYCLES = 2
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       Run,
    input  logic       Continue,
    input  logic [3:0] Opcode,
    input  logic       IR_5,
    input  logic       IR_11,
    input  logic       BEN,
    output logic       LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC, LD_LED,
    output logic       GatePC, GateMDR, GateALU, GateMARMUX,
    output logic       SR1MUX, DRMUX, SR2MUX, ADDR1MUX,
    output logic [1:0] ADDR2MUX, PCMUX, ALUK,
    output logic       MIO_EN,
    output logic       Mem_CE, Mem_UB, Mem_LB, Mem_OE, Mem_WE
);

    state_t state, state_next;
    ctrl_t  ctl;
    logic   in_wait, wait_done;

    assign in_wait = is_wait(state);

    // Clearing on done returns the counter to zero before the next access.
    mem_wait_ctr #(.WAIT_CYCLES(MEM_WAIT_CYCLES)) u_wait (
        .clk    (Clk),
        .rst_n  (Reset),
        .clear  (!in_wait || wait_done),
        .enable (in_wait),
        .done   (wait_done)
    );

    always_ff @(posedge Clk) begin
        if (!Reset)
            state <= HALTED;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            HALTED:   if (Run) state_next = FETCH1;
            FETCH1:   state_next = FETCH2;
            FETCH2:   if (wait_done) state_next = FETCH3;
            FETCH3:   state_next = DECODE;
            DECODE: begin
                case (Opcode)
                    OP_ADD:   state_next = ADD;
                    OP_AND:   state_next = AND;
                    OP_NOT:   state_next = NOT;
                    OP_BR:    state_next = BR;
                    OP_JMP:   state_next = JMP;
                    OP_JSR:   state_next = JSR1;
                    OP_LDR:   state_next = LDR1;
                    OP_STR:   state_next = STR1;
                    OP_PAUSE: state_next = PAUSE1;
                    default:  state_next = FETCH1;
                endcase
            end
            BR:       state_next = BEN ? BR_TAKEN : FETCH1;
            JSR1:     state_next = JSR2;
            LDR1:     state_next = LDR_WAIT;
            LDR_WAIT: if (wait_done) state_next = LDR3;
            STR1:     state_next = STR2;
            STR2:     state_next = STR_WAIT;
            STR_WAIT: if (wait_done) state_next = FETCH1;
            PAUSE1:   if (Continue) state_next = PAUSE2;
            PAUSE2:   if (!Continue) state_next = FETCH1;
            ADD, AND, NOT, BR_TAKEN, JMP, JSR2, LDR3:
                      state_next = FETCH1;
            default:  state_next = HALTED;
        endcase
    end

    always_comb begin
        ctl        = '0;
        ctl.mem_oe = 1'b1;
        ctl.mem_we = 1'b1;
        case (state)
            FETCH1: begin
                ctl.gate_pc = 1'b1;
                ctl.ld_mar  = 1'b1;
                ctl.ld_pc   = 1'b1;
                ctl.pcmux   = PCMUX_INC;
            end
            FETCH2, LDR_WAIT: begin
                ctl.mem_oe = 1'b0;
                ctl.mio_en = 1'b1;
                ctl.ld_mdr = 1'b1;
            end
            FETCH3: begin
                ctl.gate_mdr = 1'b1;
                ctl.ld_ir    = 1'b1;
            end
            DECODE: ctl.ld_ben = 1'b1;
            ADD, AND, NOT: begin
                ctl.sr1mux   = 1'b1;
                ctl.sr2mux   = (state == NOT) ? 1'b0 : IR_5;
                ctl.aluk     = (state == ADD) ? ALUK_ADD : (state == AND) ? ALUK_AND : ALUK_NOT;
                ctl.gate_alu = 1'b1;
                ctl.ld_reg   = 1'b1;
                ctl.ld_cc    = 1'b1;
            end
            BR_TAKEN: begin
                ctl.addr2mux = ADDR2_OFF9;
                ctl.pcmux    = PCMUX_ADDER;
                ctl.ld_pc    = 1'b1;
            end
            JMP: begin
                ctl.sr1mux   = 1'b1;
                ctl.addr1mux = 1'b1;
                ctl.addr2mux = ADDR2_ZERO;
                ctl.pcmux    = PCMUX_ADDER;
                ctl.ld_pc    = 1'b1;
            end
            JSR1: begin
                ctl.gate_pc = 1'b1;
                ctl.drmux   = 1'b1;
                ctl.ld_reg  = 1'b1;
            end
            JSR2: begin
                ctl.sr1mux   = !IR_11;
                ctl.addr1mux = !IR_11;
                ctl.addr2mux = IR_11 ? ADDR2_OFF11 : ADDR2_ZERO;
                ctl.pcmux    = PCMUX_ADDER;
                ctl.ld_pc    = 1'b1;
            end
            LDR1, STR1: begin
                ctl.sr1mux      = 1'b1;
                ctl.addr1mux    = 1'b1;
                ctl.addr2mux    = ADDR2_OFF6;
                ctl.gate_marmux = 1'b1;
                ctl.ld_mar      = 1'b1;
            end
            LDR3: begin
                ctl.gate_mdr = 1'b1;
                ctl.ld_reg   = 1'b1;
                ctl.ld_cc    = 1'b1;
            end
            STR2: begin
                ctl.aluk     = ALUK_PASSA;
                ctl.gate_alu = 1'b1;
                ctl.ld_mdr   = 1'b1;
            end
            STR_WAIT: ctl.mem_we = 1'b0;
            PAUSE1:   ctl.ld_led = 1'b1;
            default: ;
        endcase
    end

    assign {LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC, LD_LED} =
           {ctl.ld_mar, ctl.ld_mdr, ctl.ld_ir, ctl.ld_ben, ctl.ld_cc, ctl.ld_reg, ctl.ld_pc, ctl.ld_led};
    assign {GatePC, GateMDR, GateALU, GateMARMUX} =
           {ctl.gate_pc, ctl.gate_mdr, ctl.gate_alu, ctl.gate_marmux};
    assign {SR1MUX, DRMUX, SR2MUX, ADDR1MUX} = {ctl.sr1mux, ctl.drmux, ctl.sr2mux, ctl.addr1mux};
    assign {ADDR2MUX, PCMUX, ALUK} = {ctl.addr2mux, ctl.pcmux, ctl.aluk};
    assign MIO_EN = ctl.mio_en;
    assign {Mem_CE, Mem_UB, Mem_LB, Mem_OE, Mem_WE} =
           {ctl.mem_ce, ctl.mem_ub, ctl.mem_lb, ctl.mem_oe, ctl.mem_we};

endmodule

// File: tb/tb_isdu.sv
// Scoreboard bench for isdu: two instances (W = 2 and W = 3) run directed
// instruction sequences; every cycle's full control vector is checked.
module tb_isdu;

    typedef enum int {
        T_HALTED, T_FETCH1, T_FETCH2, T_FETCH3, T_DECODE,
        T_ADD, T_AND, T_NOT, T_BR, T_BR_TAKEN, T_JMP,
        T_JSR1, T_JSR2, T_LDR1, T_LDR_WAIT, T_LDR3,
        T_STR1, T_STR2, T_STR_WAIT, T_PAUSE1, T_PAUSE2
    } tstate_t;

    typedef struct packed {
        logic       ld_mar, ld_mdr, ld_ir, ld_ben, ld_cc, ld_reg, ld_pc, ld_led;
        logic       gate_pc, gate_mdr, gate_alu, gate_marmux;
        logic       sr1mux, drmux, sr2mux, addr1mux;
        logic [1:0] addr2mux, pcmux, aluk;
        logic       mio_en, mem_ce, mem_ub, mem_lb, mem_oe, mem_we;
    } vec_t;

    typedef struct {
        vec_t    vec;
        tstate_t st;
    } exp_t;

    typedef struct {
        logic [3:0] op;
        logic       ir5, ir11, ben;
    } instr_t;

    logic       clk;
    logic       reset_i [2];
    logic       run_i   [2];
    logic       cont_i  [2];
    logic [3:0] op_i    [2];
    logic       ir5_i   [2];
    logic       ir11_i  [2];
    logic       ben_i   [2];
    vec_t       got     [2];

    exp_t q0[$];
    exp_t q1[$];
    exp_t e0, e1;
    int   total = 0;
    int   bad   = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    for (genvar g = 0; g < 2; g++) begin : g_dut
        logic       ld_mar, ld_mdr, ld_ir, ld_ben, ld_cc, ld_reg, ld_pc, ld_led;
        logic       gate_pc, gate_mdr, gate_alu, gate_marmux;
        logic       sr1mux, drmux, sr2mux, addr1mux, mio_en;
        logic [1:0] addr2mux, pcmux, aluk;
        logic       mem_ce, mem_ub, mem_lb, mem_oe, mem_we;

        isdu #(.MEM_WAIT_CYCLES(g + 2)) dut (
            .Clk(clk), .Reset(reset_i[g]), .Run(run_i[g]), .Continue(cont_i[g]),
            .Opcode(op_i[g]), .IR_5(ir5_i[g]), .IR_11(ir11_i[g]), .BEN(ben_i[g]),
            .LD_MAR(ld_mar), .LD_MDR(ld_mdr), .LD_IR(ld_ir), .LD_BEN(ld_ben),
            .LD_CC(ld_cc), .LD_REG(ld_reg), .LD_PC(ld_pc), .LD_LED(ld_led),
            .GatePC(gate_pc), .GateMDR(gate_mdr), .GateALU(gate_alu), .GateMARMUX(gate_marmux),
            .SR1MUX(sr1mux), .DRMUX(drmux), .SR2MUX(sr2mux), .ADDR1MUX(addr1mux),
            .ADDR2MUX(addr2mux), .PCMUX(pcmux), .ALUK(aluk), .MIO_EN(mio_en),
            .Mem_CE(mem_ce), .Mem_UB(mem_ub), .Mem_LB(mem_lb), .Mem_OE(mem_oe), .Mem_WE(mem_we)
        );

        assign got[g] = {ld_mar, ld_mdr, ld_ir, ld_ben, ld_cc, ld_reg, ld_pc, ld_led,
                         gate_pc, gate_mdr, gate_alu, gate_marmux,
                         sr1mux, drmux, sr2mux, addr1mux, addr2mux, pcmux, aluk,
                         mio_en, mem_ce, mem_ub, mem_lb, mem_oe, mem_we};
    end

    // Expected control vector for each state, written straight from the state table.
    function automatic vec_t exp_out(input tstate_t s, input logic ir5, input logic ir11);
        vec_t v = '0;
        v.mem_oe = 1'b1;
        v.mem_we = 1'b1;
        case (s)
            T_FETCH1:   begin v.gate_pc = 1; v.ld_mar = 1; v.ld_pc = 1; end
            T_FETCH2,
            T_LDR_WAIT: begin v.mem_oe = 0; v.mio_en = 1; v.ld_mdr = 1; end
            T_FETCH3:   begin v.gate_mdr = 1; v.ld_ir = 1; end
            T_DECODE:   v.ld_ben = 1;
            T_ADD:      begin v.sr1mux = 1; v.sr2mux = ir5; v.aluk = 2'b00; v.gate_alu = 1; v.ld_reg = 1; v.ld_cc = 1; end
            T_AND:      begin v.sr1mux = 1; v.sr2mux = ir5; v.aluk = 2'b01; v.gate_alu = 1; v.ld_reg = 1; v.ld_cc = 1; end
            T_NOT:      begin v.sr1mux = 1; v.aluk = 2'b10; v.gate_alu = 1; v.ld_reg = 1; v.ld_cc = 1; end
            T_BR_TAKEN: begin v.addr2mux = 2'b10; v.pcmux = 2'b10; v.ld_pc = 1; end
            T_JMP:      begin v.sr1mux = 1; v.addr1mux = 1; v.pcmux = 2'b10; v.ld_pc = 1; end
            T_JSR1:     begin v.gate_pc = 1; v.drmux = 1; v.ld_reg = 1; end
            T_JSR2: begin
                if (ir11) v.addr2mux = 2'b11;
                else begin v.sr1mux = 1; v.addr1mux = 1; end
                v.pcmux = 2'b10;
                v.ld_pc = 1;
            end
            T_LDR1,
            T_STR1:     begin v.sr1mux = 1; v.addr1mux = 1; v.addr2mux = 2'b01; v.gate_marmux = 1; v.ld_mar = 1; end
            T_LDR3:     begin v.gate_mdr = 1; v.ld_reg = 1; v.ld_cc = 1; end
            T_STR2:     begin v.aluk = 2'b11; v.gate_alu = 1; v.ld_mdr = 1; end
            T_STR_WAIT: v.mem_we = 0;
            T_PAUSE1:   v.ld_led = 1;
            default: ;
        endcase
        return v;
    endfunction

    task automatic check_output(input int k, input exp_t e, input vec_t a);
        total++;
        if (a !== e.vec) begin
            bad++;
            $display("[TB] FAIL dut%0d state=%s t=%0t got=%h required=%h",
                     k, e.st.name(), $time, a, e.vec);
        end
    endtask

    // Monitor: one expected entry per clock per instance, checked mid-cycle.
    always @(negedge clk) begin
        if (q0.size() > 0) begin
            e0 = q0.pop_front();
            check_output(0, e0, got[0]);
        end
        if (q1.size() > 0) begin
            e1 = q1.pop_front();
            check_output(1, e1, got[1]);
        end
    end

    task automatic step(input int k, input tstate_t s);
        exp_t e;
        @(posedge clk);
        #1;
        e.st  = s;
        e.vec = exp_out(s, ir5_i[k], ir11_i[k]);
        if (k == 0) q0.push_back(e);
        else        q1.push_back(e);
    endtask

    task automatic apply_stimulus(input int k, input instr_t in);
        op_i[k]   = in.op;
        ir5_i[k]  = in.ir5;
        ir11_i[k] = in.ir11;
        ben_i[k]  = in.ben;
    endtask

    task automatic fetch(input int k, input int w);
        repeat (w) step(k, T_FETCH2);
        step(k, T_FETCH3);
        step(k, T_DECODE);
    endtask

    // Starts and ends in FETCH1.
    task automatic exec_instr(input int k, input int w, input instr_t in);
        apply_stimulus(k, in);
        fetch(k, w);
        case (in.op)
            4'b0001: step(k, T_ADD);
            4'b0101: step(k, T_AND);
            4'b1001: step(k, T_NOT);
            4'b0000: begin step(k, T_BR); if (in.ben) step(k, T_BR_TAKEN); end
            4'b1100: step(k, T_JMP);
            4'b0100: begin step(k, T_JSR1); step(k, T_JSR2); end
            4'b0110: begin step(k, T_LDR1); repeat (w) step(k, T_LDR_WAIT); step(k, T_LDR3); end
            4'b0111: begin step(k, T_STR1); step(k, T_STR2); repeat (w) step(k, T_STR_WAIT); end
            default: ;
        endcase
        step(k, T_FETCH1);
    endtask

    task automatic pause_instr(input int k, input int w, input logic early_cont);
        instr_t p = '{op: 4'b1101, ir5: 1'b0, ir11: 1'b0, ben: 1'b0};
        apply_stimulus(k, p);
        cont_i[k] = early_cont;
        fetch(k, w);
        step(k, T_PAUSE1);
        if (!early_cont) begin
            step(k, T_PAUSE1);
            step(k, T_PAUSE1);
            cont_i[k] = 1'b1;
        end
        repeat (10) step(k, T_PAUSE2);
        cont_i[k] = 1'b0;
        step(k, T_FETCH1);
    endtask

    task automatic run_dut(input int k);
        int     w = k + 2;
        instr_t ldr = '{op: 4'b0110, ir5: 1'b0, ir11: 1'b0, ben: 1'b0};
        instr_t vecs [13] = '{
            '{4'b0001, 1'b1, 1'b0, 1'b0},
            '{4'b0001, 1'b0, 1'b1, 1'b1},
            '{4'b0101, 1'b1, 1'b0, 1'b0},
            '{4'b1001, 1'b1, 1'b1, 1'b0},
            '{4'b0000, 1'b0, 1'b0, 1'b0},
            '{4'b0000, 1'b0, 1'b0, 1'b1},
            '{4'b1100, 1'b0, 1'b0, 1'b1},
            '{4'b0100, 1'b0, 1'b0, 1'b0},
            '{4'b0100, 1'b1, 1'b1, 1'b0},
            '{4'b0110, 1'b1, 1'b0, 1'b0},
            '{4'b0111, 1'b0, 1'b1, 1'b0},
            '{4'b1111, 1'b1, 1'b1, 1'b1},
            '{4'b0010, 1'b0, 1'b0, 1'b0}
        };
        reset_i[k] = 1'b0;
        run_i[k]   = 1'b1;
        step(k, T_HALTED);
        step(k, T_HALTED);
        reset_i[k] = 1'b1;
        run_i[k]   = 1'b0;
        step(k, T_HALTED);
        step(k, T_HALTED);
        run_i[k] = 1'b1;
        step(k, T_FETCH1);
        foreach (vecs[i]) exec_instr(k, w, vecs[i]);
        pause_instr(k, w, 1'b0);
        pause_instr(k, w, 1'b1);
        // Reset in the middle of a load's memory wait, then a clean load.
        apply_stimulus(k, ldr);
        fetch(k, w);
        step(k, T_LDR1);
        step(k, T_LDR_WAIT);
        reset_i[k] = 1'b0;
        step(k, T_HALTED);
        reset_i[k] = 1'b1;
        step(k, T_FETCH1);
        exec_instr(k, w, ldr);
        reset_i[k] = 1'b0;
        step(k, T_HALTED);
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            reset_i[k] = 1'b0;
            run_i[k]   = 1'b0;
            cont_i[k]  = 1'b0;
            op_i[k]    = 4'b0000;
            ir5_i[k]   = 1'b0;
            ir11_i[k]  = 1'b0;
            ben_i[k]   = 1'b0;
        end
        $display("[TB] starting");
        run_dut(0);
        run_dut(1);
        @(negedge clk);
        @(negedge clk);
        total++;
        if (q0.size() + q1.size() != 0) begin
            bad++;
            $display("[TB] FAIL drain got=%0d required=0", q0.size() + q1.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        bad++;
        $display("[TB] FAIL timeout got=running required=finished");
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "[TB] timeout");
    end

endmodule

// File: doc/isdu.md
Name: isdu

Overview:
Instruction sequence and decode unit for the LC-3 datapath. A Moore FSM that fetches, decodes and executes a subset of instructions: ADD, AND, NOT, BR, JMP, JSR/JSRR, LDR, STR and PAUSE. It drives the register file controls (SR1MUX, DRMUX, LD_REG) and all other datapath load, gate, mux and memory controls. It sits directly upstream of the register file.

Parameters:
MEM_WAIT_CYCLES, 2, number of cycles per SRAM read/write access state. Legal range 1..15.

Ports:
Clk  input  1  system clock; all state updates on rising edge
Reset  input  1  synchronous, active-low; forces HALTED
Run  input  1  start execution from HALTED (level, active-high)
Continue  input  1  resume from PAUSE (level, active-high)
Opcode  input  4  IR[15:12]
IR_5  input  1  IR[5]: immediate select for ADD/AND
IR_11  input  1  IR[11]: JSR (1) vs JSRR (0)
BEN  input  1  registered branch enable from the datapath
LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC, LD_LED  output  1 each  register load enables
GatePC, GateMDR, GateALU, GateMARMUX  output  1 each  bus drivers; at most one high per cycle
SR1MUX  output  1  1 = IR[8:6], 0 = IR[11:9]
DRMUX  output  1  0 = IR[11:9], 1 = R7
SR2MUX  output  1  0 = SR2 register, 1 = sext imm5
ADDR1MUX  output  1  0 = PC, 1 = SR1_OUT
ADDR2MUX  output  2  00 zero, 01 off6, 10 off9, 11 off11
PCMUX  output  2  00 PC+1, 01 BUS, 10 address adder
ALUK  output  2  00 ADD, 01 AND, 10 NOT, 11 PASS A
MIO_EN  output  1  1 = MDR loads from memory, 0 = from bus
Mem_CE, Mem_UB, Mem_LB, Mem_OE, Mem_WE  output  1 each  SRAM controls, active-low

Behaviour:
- Outputs are a pure decode of the current state. In any state, every output not listed for that state is 0, except Mem_OE and Mem_WE, which are 1. Mem_CE, Mem_UB and Mem_LB are always 0.
- Reset low at a clock edge puts the FSM in HALTED and clears the wait counter. This applies in any state, including mid-wait. Output values in HALTED are the defaults above.
- HALTED: go to FETCH1 when Run = 1; otherwise stay.
- FETCH1: GatePC, LD_MAR, LD_PC, PCMUX = 00.
- FETCH2 (read wait): Mem_OE = 0, MIO_EN = 1, LD_MDR. Lasts exactly MEM_WAIT_CYCLES cycles, then goes to FETCH3.
- FETCH3: GateMDR, LD_IR. Next state is DECODE.
- DECODE: LD_BEN. Next state by Opcode:
  - 0001 ADD, 0101 AND, 1001 NOT, 0000 BR
  - 1100 JMP, 0100 JSR1, 0110 LDR1, 0111 STR1, 1101 PAUSE1
  - any other opcode: FETCH1 (treated as NOP)
- ADD/AND: SR1MUX = 1, DRMUX = 0, SR2MUX = IR_5, ALUK = 00 (ADD) or 01 (AND), GateALU, LD_REG, LD_CC. Next state FETCH1.
- NOT: same as ADD/AND with ALUK = 10, SR2MUX = 0.
- BR: no outputs. Go to BR_TAKEN if BEN = 1, else FETCH1.
- BR_TAKEN: ADDR1MUX = 0, ADDR2MUX = 10, PCMUX = 10, LD_PC. Next state FETCH1.
- JMP: SR1MUX = 1, ADDR1MUX = 1, ADDR2MUX = 00, PCMUX = 10, LD_PC. Next state FETCH1.
- JSR1: GatePC, DRMUX = 1, LD_REG (R7 <- PC). Next state JSR2.
- JSR2:
  - if IR_11 = 1: ADDR1MUX = 0, ADDR2MUX = 11
  - if IR_11 = 0: SR1MUX = 1, ADDR1MUX = 1, ADDR2MUX = 00
  - in both cases PCMUX = 10, LD_PC. Next state FETCH1.
- LDR1: SR1MUX = 1, ADDR1MUX = 1, ADDR2MUX = 01, GateMARMUX, LD_MAR. Next state LDR_WAIT.
- LDR_WAIT: same outputs as FETCH2, for MEM_WAIT_CYCLES cycles. Next state LDR3.
- LDR3: GateMDR, DRMUX = 0, LD_REG, LD_CC. Next state FETCH1.
- STR1: same outputs as LDR1. Next state STR2.
- STR2: SR1MUX = 0, ALUK = 11, GateALU, MIO_EN = 0, LD_MDR. Next state STR_WAIT.
- STR_WAIT: Mem_WE = 0 for MEM_WAIT_CYCLES cycles; Mem_OE stays 1. Next state FETCH1.
- PAUSE1: LD_LED. Stay while Continue = 0; go to PAUSE2 when Continue = 1.
- PAUSE2: stay while Continue = 1; go to FETCH1 when Continue = 0. Holding Continue high never runs more than one instruction.
- Wait counter:
  - 4 bits; cleared on entry to any wait state.
  - increments each cycle in a wait state; the FSM exits when count = MEM_WAIT_CYCLES - 1.
  - cleared outside wait states.
- Run is ignored outside HALTED. There is no halt opcode; only Reset returns the FSM to HALTED.
- Instruction latency (W = MEM_WAIT_CYCLES), counted from FETCH1 to the next FETCH1:
  - ADD/AND/NOT/JMP: W + 4
  - BR not taken: W + 4; BR taken: W + 5
  - JSR: W + 5
  - LDR: 2W + 5
  - STR: 2W + 5

Decomposition:
- Package isdu_pkg holds:
  - state_t enum: HALTED, FETCH1..3, DECODE, ADD, AND, NOT, BR, BR_TAKEN, JMP, JSR1..2, LDR1, LDR_WAIT, LDR3, STR1, STR2, STR_WAIT, PAUSE1..2
  - opcode constants
  - ALUK/PCMUX/ADDR2MUX encodings, shared with the ALU and PC logic
- Sub-module mem_wait_ctr: clear/enable counter with a done flag at MEM_WAIT_CYCLES - 1.

Test Plan:
- Reset low for 2 cycles with Run = 1 -> state HALTED, Mem_OE = 1, Mem_WE = 1, all loads 0; after Reset goes high, FETCH1 on the next edge.
- W = 2, Opcode = 0001, IR_5 = 1 -> sequence FETCH1, FETCH2 ×2, FETCH3, DECODE, ADD, FETCH1. In ADD: LD_REG = 1, SR2MUX = 1, ALUK = 00.
- Opcode = 0000 with BEN = 0 -> BR to FETCH1 with no LD_PC. Repeat with BEN = 1 -> BR_TAKEN with PCMUX = 10, ADDR2MUX = 10.
- Opcode = 0100, IR_11 = 0 -> JSR1 (DRMUX = 1, GatePC) then JSR2 (ADDR1MUX = 1, PCMUX = 10).
- Opcode = 0111, W = 3 -> Mem_WE = 0 for exactly 3 consecutive cycles, and MIO_EN = 0 in STR2.
- Opcode = 1101, hold Continue = 1 for 10 cycles -> LD_LED = 1 in PAUSE1, no progress past PAUSE2 until Continue = 0.
- Reset asserted mid-LDR_WAIT -> HALTED on that edge, and counter reads 0 on the next access.
